ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset.
REQ-003 ex_valid  in  1  ID/EX register holds a real instruction (0 = bubble).
REQ-004 ex_opcode  in  5; ex_immediate  in  8; ex_rs, ex_rt, ex_rd  in  3 each; ex_rd1, ex_rd2  in  32 each: operation, immediate, register indices and register-file read data from the ID/EX register.
REQ-005 ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc, ex_regdist  in  1 each: control bits from the ID/EX register.
REQ-006 wb_regwrite  in  1; wb_rd  in  3; wb_data  in  32: write-back port, used for forwarding.
REQ-007 stall  out  1  ID/EX and earlier stages SHALL hold their contents while high.
REQ-008 mem_valid, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite  out  1 each; mem_alu_result, mem_store_data  out  32 each; mem_wreg  out  3: the EX/MEM pipeline register.

Function
REQ-009 Operand A SHALL be the forwarded ex_rd1; operand B SHALL be sign-extended ex_immediate when ex_alusrc=1, else the forwarded ex_rd2.
REQ-010 Forwarding priority for a source index s≠0: (1) the EX/MEM register when mem_valid & mem_regwrite & !mem_memread & mem_wreg==s; (2) the WB port when wb_regwrite & wb_rd==s; (3) the register-file value. Index 0 SHALL never be forwarded.
REQ-011 mem_store_data SHALL be the forwarded ex_rd2, independent of ex_alusrc.
REQ-012 Destination: mem_wreg <= ex_regdist ? ex_rd : ex_rt.
REQ-013 Operations: ADD 5'h00, SUB 5'h01, AND 5'h02, OR 5'h03, XOR 5'h04, SLL 5'h05, SRL 5'h06 (shift amount B[4:0]), MUL 5'h07 (low 32 bits of product), SLT 5'h08 (signed, result 1/0). Any other opcode SHALL produce result 0. Arithmetic wraps modulo 2^32.
REQ-014 Single-cycle ops: one-cycle latency. The EX/MEM register loads on the edge after the instruction is presented; stall stays low.
REQ-015 MUL SHALL use a two-state FSM, IDLE and BUSY, with a radix-4 shift-add engine (2 bits per cycle, 16 iterations).
REQ-016 IDLE->BUSY when ex_valid & opcode==MUL. stall SHALL be high combinationally in that cycle and in every BUSY cycle except the last.
REQ-017 Timing: the result SHALL be loaded into the EX/MEM register with mem_valid=1 exactly 17 edges after acceptance. The FSM SHALL return to IDLE on that edge.
REQ-018 While stall is high, the EX/MEM register SHALL load a bubble: mem_valid=0 and all mem_* control bits 0.
REQ-019 Operands SHALL be captured at acceptance. Changes on the inputs during BUSY SHALL be ignored.
REQ-020 When ex_valid=0, the EX/MEM register SHALL load a bubble.
REQ-021 Load-use hazards are out of scope; the upstream hazard unit inserts the bubble.

Reset
REQ-022 While rst_n=0 at an edge: FSM->IDLE, iteration counter=0, mem_valid and all mem_* control bits=0, mem_alu_result=0, mem_store_data=0, mem_wreg=0.
REQ-023 A reset during BUSY SHALL abort the multiply with no result written. stall SHALL be low in the first cycle after reset unless a new MUL is presented.

Configuration
REQ-024 Macro EX_MUL_EN.
- Defined: MUL behaves per REQ-015..019.
- Undefined: no FSM or multiplier is built; MUL yields result 0 in one cycle and stall is constantly 0.

Structure
REQ-025 Shared package cpu_pkg holds the 5-bit opcode constants, the 32-bit data width, the 3-bit register-index width and the MUL iteration count.
REQ-026 Sub-module mul_iter SHALL contain the radix-4 shift-add engine (start, busy, done, 32-bit product). ex_stage holds forwarding, ALU, FSM and the EX/MEM register.

Verification
REQ-027 ADD with rd1=5, rd2=7, regdist=1, rd=3 -> next edge: mem_alu_result=12, mem_wreg=3, mem_valid=1, stall=0.
REQ-028 alusrc=1, immediate=8'hFF, rd1=10, ADD -> mem_alu_result=9 (sign-extension).
REQ-029 Back-to-back ADD r1 then SUB using r1 (stale rd1=0, forwarded value 20, rd2=5) -> result 15. With the EX/MEM match removed and WB supplying wb_rd=1, wb_data=30 -> result 25. Source r0 is never forwarded.
REQ-030 MUL 32'h0001_0003 × 32'h0000_0005 -> stall high 16 cycles, bubbles in EX/MEM, then mem_alu_result=32'h0005_000F with mem_valid=1 on edge 17. Same case with EX_MUL_EN undefined -> result 0 after 1 cycle, stall never high.
REQ-031 Drop rst_n at cycle 6 of a MUL -> next cycle stall=0, mem_valid=0, no product ever appears.
REQ-032 Opcode 5'h1F with ex_valid=1 -> result 0. The same instruction with ex_valid=0 -> mem_valid=0 and mem_regwrite=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants, widths, EX/MEM register layout and ALU helpers
// used by the execute stage and its multiplier engine.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_W      = 3;
    localparam int OP_W       = 5;
    localparam int MUL_ITERS  = 16;
    localparam int MUL_CNT_W  = $clog2(MUL_ITERS + 1);

    localparam logic [OP_W-1:0] OP_ADD = 5'h00;
    localparam logic [OP_W-1:0] OP_SUB = 5'h01;
    localparam logic [OP_W-1:0] OP_AND = 5'h02;
    localparam logic [OP_W-1:0] OP_OR  = 5'h03;
    localparam logic [OP_W-1:0] OP_XOR = 5'h04;
    localparam logic [OP_W-1:0] OP_SLL = 5'h05;
    localparam logic [OP_W-1:0] OP_SRL = 5'h06;
    localparam logic [OP_W-1:0] OP_MUL = 5'h07;
    localparam logic [OP_W-1:0] OP_SLT = 5'h08;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mul_state_e;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memtoreg;
        logic              memread;
        logic              memwrite;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  wreg;
    } exmem_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [7:0] imm);
        return {{(DATA_W-8){imm[7]}}, imm};
    endfunction

    // MUL is not handled here: it either goes through the iterative engine
    // or, with the engine compiled out, yields 0 like any unknown opcode.
    function automatic logic [DATA_W-1:0] alu_op(input logic [OP_W-1:0]   op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SLT:  r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Radix-4 shift-add multiplier: consumes two multiplier bits per cycle,
// the first pair on the start edge, producing the low 32 product bits.
module mul_iter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    logic [DATA_W-1:0]    acc_q;
    logic [DATA_W-1:0]    mcand_q;
    logic [DATA_W-1:0]    mplier_q;
    logic [MUL_CNT_W-1:0] cnt_q;
    logic                 busy_q;

    function automatic logic [DATA_W-1:0] partial(input logic [DATA_W-1:0] m,
                                                  input logic [1:0]        d);
        logic [DATA_W-1:0] p;
        p = '0;
        case (d)
            2'd0: p = '0;
            2'd1: p = m;
            2'd2: p = m << 1;
            2'd3: p = m + (m << 1);
            default: p = '0;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= partial(op_a_i, op_b_i[1:0]);
            mcand_q  <= op_a_i << 2;
            mplier_q <= op_b_i >> 2;
            cnt_q    <= MUL_CNT_W'(1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == MUL_CNT_W'(MUL_ITERS)) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                acc_q    <= acc_q + partial(mcand_q, mplier_q[1:0]);
                mcand_q  <= mcand_q << 2;
                mplier_q <= mplier_q >> 2;
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == MUL_CNT_W'(MUL_ITERS));
    assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative MUL sequencing and the
// EX/MEM pipeline register. The multiplier is built only with EX_MUL_EN.
//
// state  | meaning
// S_IDLE | single-cycle ops flow through; a valid MUL is accepted here
// S_BUSY | multiplier iterating; EX/MEM gets bubbles until done
module ex_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   ex_opcode,
    input  logic [7:0]        ex_immediate,
    input  logic [REG_W-1:0]  ex_rs,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_rd1,
    input  logic [DATA_W-1:0] ex_rd2,
    input  logic              ex_regwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_alusrc,
    input  logic              ex_regdist,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              mem_valid,
    output logic              mem_regwrite,
    output logic              mem_memtoreg,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_wreg
);

    exmem_t            mem_q;
    exmem_t            mem_d;
    exmem_t            instr_word;
    logic              mem_fwd_ok;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;

    // A load in EX/MEM has no data yet, so it is never a forwarding source.
    assign mem_fwd_ok = mem_q.valid && mem_q.regwrite && !mem_q.memread;

    always_comb begin
        fwd_a = ex_rd1;
        if (ex_rs != '0 && mem_fwd_ok && mem_q.wreg == ex_rs) begin
            fwd_a = mem_q.alu_result;
        end else if (ex_rs != '0 && wb_regwrite && wb_rd == ex_rs) begin
            fwd_a = wb_data;
        end
    end

    always_comb begin
        fwd_b = ex_rd2;
        if (ex_rt != '0 && mem_fwd_ok && mem_q.wreg == ex_rt) begin
            fwd_b = mem_q.alu_result;
        end else if (ex_rt != '0 && wb_regwrite && wb_rd == ex_rt) begin
            fwd_b = wb_data;
        end
    end

    assign op_b = ex_alusrc ? sext_imm(ex_immediate) : fwd_b;

    always_comb begin
        instr_word            = '0;
        instr_word.valid      = 1'b1;
        instr_word.regwrite   = ex_regwrite;
        instr_word.memtoreg   = ex_memtoreg;
        instr_word.memread    = ex_memread;
        instr_word.memwrite   = ex_memwrite;
        instr_word.alu_result = alu_op(ex_opcode, fwd_a, op_b);
        instr_word.store_data = fwd_b;
        instr_word.wreg       = ex_regdist ? ex_rd : ex_rt;
    end

`ifdef EX_MUL_EN
    mul_state_e        state_q;
    mul_state_e        state_d;
    exmem_t            pend_q;
    exmem_t            pend_d;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    mul_iter u_mul_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .op_a_i    (fwd_a),
        .op_b_i    (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        mem_d     = '0;
        stall     = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ex_valid && ex_opcode == OP_MUL) begin
                    stall     = 1'b1;
                    mul_start = 1'b1;
                    pend_d    = instr_word;
                    state_d   = S_BUSY;
                end else if (ex_valid) begin
                    mem_d = instr_word;
                end
            end
            S_BUSY: begin
                if (mul_busy && mul_done) begin
                    mem_d            = pend_q;
                    mem_d.alu_result = mul_product;
                    state_d          = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end
`else
    assign stall = 1'b0;
    assign mem_d = ex_valid ? instr_word : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign mem_valid      = mem_q.valid;
    assign mem_regwrite   = mem_q.regwrite;
    assign mem_memtoreg   = mem_q.memtoreg;
    assign mem_memread    = mem_q.memread;
    assign mem_memwrite   = mem_q.memwrite;
    assign mem_alu_result = mem_q.alu_result;
    assign mem_store_data = mem_q.store_data;
    assign mem_wreg       = mem_q.wreg;

endmodule
